bcd_down_timer: RTL and testbench

- Loadable multi-digit BCD countdown timer. It is the decrementing counterpart to the team's decade up-counters.
- Decrements one BCD value per prescaled tick, digit-wise with borrow (0 -> 9 plus borrow to the next digit).
- Pulses done_o on reaching zero.
- Used as the countdown/timeout source next to the up-counters in the practice designs.

---
 rtl/bcd_down_timer_if.sv | 23 ++
 rtl/bcd_down_timer.sv | 146 ++++++++++++++
 tb/tb_bcd_down_timer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_down_timer_if.sv
// Handshake/bus bundle for bcd_down_timer: control inputs and status outputs.
// The master drives the controls. The timer sits on the slave side.
interface bcd_down_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load_i;
    logic [4*DIGITS-1:0]   load_val_i;
    logic                  start_i;
    logic                  pause_i;
    logic [4*DIGITS-1:0]   count_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output load_i, load_val_i, start_i, pause_i,
        input  count_o, busy_o, done_o
    );

    modport slave (
        input  load_i, load_val_i, start_i, pause_i,
        output count_o, busy_o, done_o
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with prescaler, pause/resume and
// a one-cycle done pulse on reaching zero.
// Optional feature macro: BCD_TIMER_AUTO_RELOAD_EN. When it is defined, reaching
// zero reloads the last loaded value and keeps running, which gives a periodic tick.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | holding count, waiting for start_i (ignored when count is 0)
// S_RUN   | prescaler running, count decrements once per TICK_DIV clocks
// S_PAUSE | count and prescaler frozen until start_i
// S_DONE  | single cycle with done_o high and count 0, then back to idle
module bcd_down_timer #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    bcd_down_timer_if.slave      bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [W-1:0]    count_q;
    logic [PW-1:0]   presc_q;
    logic            busy_q;
    logic            done_q;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [W-1:0]    reload_q;
`endif

    logic [W-1:0]    load_san_d;
    logic [W-1:0]    count_dec_d;
    logic            dec_borrow_d;

    // Clamp every load digit above 9 to 9 so the count is always valid BCD.
    always_comb begin
        load_san_d = bus.load_val_i;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.load_val_i[4*d +: 4] > 4'd9) begin
                load_san_d[4*d +: 4] = 4'd9;
            end
        end
    end

    // Digit-wise BCD decrement; a 0 digit becomes 9 and passes the borrow upward.
    always_comb begin
        count_dec_d  = count_q;
        dec_borrow_d = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (dec_borrow_d) begin
                if (count_q[4*d +: 4] == 4'd0) begin
                    count_dec_d[4*d +: 4] = 4'd9;
                end else begin
                    count_dec_d[4*d +: 4] = count_q[4*d +: 4] - 4'd1;
                    dec_borrow_d          = 1'b0;
                end
            end
        end
    end

    // Timer FSM with count, prescaler and registered busy/done outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.load_i) begin
                count_q  <= load_san_d;
                presc_q  <= '0;
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                reload_q <= load_san_d;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start_i && (count_q != '0)) begin
                            state_q <= S_RUN;
                            presc_q <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (bus.pause_i) begin
                            state_q <= S_PAUSE;
                            busy_q  <= 1'b0;
                        end else if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            done_q  <= (count_dec_d == '0);
                            if (count_dec_d == '0) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                                // A zero reload value falls back to one-shot.
                                if (reload_q != '0) begin
                                    count_q <= reload_q;
                                end else begin
                                    count_q <= '0;
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                end
`else
                                count_q <= '0;
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
`endif
                            end else begin
                                count_q <= count_dec_d;
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (!bus.pause_i && bus.start_i) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.count_o = count_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a decimal-integer model.
module tb_bcd_down_timer;
    localparam bit AUTO =
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        1'b1;
`else
        1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;

    bcd_down_timer_if #(.DIGITS(2)) if1 ();
    bcd_down_timer_if #(.DIGITS(2)) if3 ();

    bcd_down_timer #(.DIGITS(2), .TICK_DIV(1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
    bcd_down_timer #(.DIGITS(2), .TICK_DIV(3)) dut3 (.clk(clk), .rstn(rstn), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int val;      // count as a plain decimal integer
        int reload;
        int mode;
        int presc;
        bit done;
    } model_t;

    typedef struct {
        bit         ld;
        logic [7:0] lv;
        bit         st;
        bit         pa;
        logic [7:0] cnt;
        bit         busy;
        bit         done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input bit ld, input logic [7:0] lv, input bit st, input bit pa);
        if1.load_i = ld; if1.load_val_i = lv; if1.start_i = st; if1.pause_i = pa;
    endtask

    task automatic drive3(input bit ld, input logic [7:0] lv, input bit st, input bit pa);
        if3.load_i = ld; if3.load_val_i = lv; if3.start_i = st; if3.pause_i = pa;
    endtask

    function automatic int san(input logic [7:0] lv);
        int hi;
        int lo;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    function automatic model_t step(input model_t m, input int td, input bit ld,
                                    input logic [7:0] lv, input bit st, input bit pa);
        model_t n;
        n = m;
        n.done = 1'b0;
        if (ld) begin
            n.val = san(lv); n.reload = n.val; n.presc = 0; n.mode = M_IDLE;
        end else if (m.mode == M_IDLE) begin
            if (st && m.val != 0) begin n.mode = M_RUN; n.presc = 0; end
        end else if (m.mode == M_RUN) begin
            if (pa) begin
                n.mode = M_PAUSE;
            end else if (m.presc == td - 1) begin
                n.presc = 0;
                n.val = m.val - 1;
                if (n.val == 0) begin
                    n.done = 1'b1;
                    if (AUTO && m.reload != 0) n.val = m.reload;
                    else n.mode = M_DONE;
                end
            end else begin
                n.presc = m.presc + 1;
            end
        end else if (m.mode == M_PAUSE) begin
            if (st) n.mode = M_RUN;
        end else begin
            n.mode = M_IDLE;
        end
        return n;
    endfunction

    vec_t   vecs[20];
    model_t m1;
    model_t m3;
    bit     seen_done;
    bit     r_ld;
    bit     r_st;
    bit     r_pa;
    logic [7:0] r_lv;
    int     sel;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rstn    = 1'b0;
        drive1(0, 8'h00, 0, 0);
        drive3(0, 8'h00, 0, 0);

        // reset state before any clock edge
        #1;
        chk("rst count1", if1.count_o, 8'h00);
        chk("rst busy1",  if1.busy_o,  1'b0);
        chk("rst done1",  if1.done_o,  1'b0);
        chk("rst count3", if3.count_o, 8'h00);
        tick();
        tick();
        rstn = 1'b1;

`ifndef BCD_TIMER_AUTO_RELOAD_EN
        // basic countdown, sanitise/priority, start-at-zero on dut1
        vecs[0]  = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 8'hAF, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 8'h5C, 1'b0, 1'b0, 8'h59, 1'b0, 1'b0};
        for (int i = 0; i < 20; i++) begin
            drive1(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa);
            tick();
            chk($sformatf("vec%0d count", i), if1.count_o, vecs[i].cnt);
            chk($sformatf("vec%0d busy", i),  if1.busy_o,  vecs[i].busy);
            chk($sformatf("vec%0d done", i),  if1.done_o,  vecs[i].done);
        end
        drive1(0, 8'h00, 0, 0);
`endif

        // prescaler and pause on the TICK_DIV=3 instance
        drive3(1, 8'h05, 0, 0); tick();
        chk("pz load", if3.count_o, 8'h05);
        drive3(0, 8'h00, 1, 0); tick();
        chk("pz start busy", if3.busy_o, 1'b1);
        drive3(0, 8'h00, 0, 0);
        repeat (7) tick();
        chk("pz 7clk count", if3.count_o, 8'h03);
        drive3(0, 8'h00, 0, 1); tick();
        chk("pz paused busy", if3.busy_o, 1'b0);
        drive3(0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("pz hold%0d", i), if3.count_o, 8'h03);
        end
        drive3(0, 8'h00, 1, 0); tick();
        chk("pz resume busy", if3.busy_o, 1'b1);
        drive3(0, 8'h00, 0, 0);
        tick(); tick();
        chk("pz resume+2", if3.count_o, 8'h02);
        repeat (5) tick();
        chk("pz resume+7 count", if3.count_o, 8'h01);
        chk("pz resume+7 done",  if3.done_o,  1'b0);
        tick();
        chk("pz resume+8 count", if3.count_o, AUTO ? 8'h05 : 8'h00);
        chk("pz resume+8 done",  if3.done_o,  1'b1);
        drive3(1, 8'h00, 0, 0); tick();
        drive3(0, 8'h00, 0, 0);

        // load while running aborts to IDLE with the new value and no done pulse
        seen_done = 1'b0;
        drive1(1, 8'h40, 0, 0); tick();
        drive1(0, 8'h00, 1, 0); tick();
        drive1(0, 8'h00, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (if1.count_o == 8'h25) break;
            tick();
            if (if1.done_o) seen_done = 1'b1;
        end
        chk("rl reach25", if1.count_o, 8'h25);
        drive1(1, 8'h03, 0, 0); tick();
        chk("rl count", if1.count_o, 8'h03);
        chk("rl busy",  if1.busy_o,  1'b0);
        if (if1.done_o) seen_done = 1'b1;
        drive1(0, 8'h00, 0, 0);
        repeat (3) begin
            tick();
            if (if1.done_o) seen_done = 1'b1;
        end
        chk("rl hold", if1.count_o, 8'h03);
        chk("rl no done", seen_done, 1'b0);

        // asynchronous reset in the middle of a run
        drive1(1, 8'h37, 0, 0); tick();
        drive1(0, 8'h00, 1, 0); tick();
        drive1(0, 8'h00, 0, 0);
        chk("ar run busy",  if1.busy_o,  1'b1);
        chk("ar run count", if1.count_o, 8'h37);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar count", if1.count_o, 8'h00);
        chk("ar busy",  if1.busy_o,  1'b0);
        chk("ar done",  if1.done_o,  1'b0);
        #1;
        rstn = 1'b1;
        tick();

`ifdef BCD_TIMER_AUTO_RELOAD_EN
        // periodic tick with reload value 3
        drive1(1, 8'h03, 0, 0); tick();
        drive1(0, 8'h00, 1, 0); tick();
        drive1(0, 8'h00, 0, 0);
        for (int j = 1; j <= 21; j++) begin
            tick();
            chk($sformatf("auto busy%0d", j), if1.busy_o, 1'b1);
            chk($sformatf("auto done%0d", j), if1.done_o, (j % 3) == 0);
            if ((j % 3) == 0) chk($sformatf("auto count%0d", j), if1.count_o, 8'h03);
        end
`endif

        // randomized stimulus against the integer model on both instances
        tick();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        m1 = '{val:0, reload:0, mode:M_IDLE, presc:0, done:1'b0};
        m3 = m1;
        for (int c = 0; c < 1500; c++) begin
            r_ld = ($urandom_range(0, 29) == 0);
            r_lv = $urandom_range(0, 1) ? 8'($urandom) : {4'h0, 4'($urandom_range(0, 15))};
            sel  = $urandom_range(0, 15);
            r_st = (sel < 3);
            r_pa = (sel == 3);
            drive1(r_ld, r_lv, r_st, r_pa);
            m1 = step(m1, 1, r_ld, r_lv, r_st, r_pa);

            r_ld = ($urandom_range(0, 39) == 0);
            r_lv = $urandom_range(0, 1) ? 8'($urandom) : {4'h0, 4'($urandom_range(0, 15))};
            sel  = $urandom_range(0, 15);
            r_st = (sel < 3);
            r_pa = (sel == 3);
            drive3(r_ld, r_lv, r_st, r_pa);
            m3 = step(m3, 3, r_ld, r_lv, r_st, r_pa);

            tick();
            chk($sformatf("rnd1 count c%0d", c), if1.count_o, to_bcd(m1.val));
            chk($sformatf("rnd1 busy c%0d", c),  if1.busy_o,  m1.mode == M_RUN);
            chk($sformatf("rnd1 done c%0d", c),  if1.done_o,  m1.done);
            chk($sformatf("rnd3 count c%0d", c), if3.count_o, to_bcd(m3.val));
            chk($sformatf("rnd3 busy c%0d", c),  if3.busy_o,  m3.mode == M_RUN);
            chk($sformatf("rnd3 done c%0d", c),  if3.done_o,  m3.done);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
